// File: rtl/confused_pkg.sv
// Shared definitions for the ConfusedCore interconnect blocks.
//   WORD_W : native data word width ("hmmm word")
//   idx_w  : bits needed to name one of n channels, never less than 1
package confused_pkg;

  localparam int WORD_W = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_mux_reg_rr_arbiter.sv
// rr_arbiter: one-hot arbiter over N requesters, fixed priority or round-robin.
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high reset (ptr -> 0)
//   req       in   N request lines
//   advance   in   a granted request was accepted this cycle; moves ptr (RR only)
//   grant     out  one-hot grant, zero when no request
//   grant_idx out  binary index of the granted requester (0 when none)
module rr_arbiter
  import confused_pkg::*;
#(
  parameter int N  = 4,
  parameter int RR = 1,
  localparam int IDXW = idx_w(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx
);

  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] jj;
  logic            found;
  int              j;

  // Search starts at ptr (RR) or 0 (fixed priority) and wraps once around.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    jj        = '0;
    for (int k = 0; k < N; k++) begin
      j = (RR != 0) ? int'(ptr) + k : k;
      if (j >= N) j = j - N;
      jj = IDXW'(j);
      if (!found && req[jj]) begin
        found     = 1'b1;
        grant[jj] = 1'b1;
        grant_idx = jj;
      end
    end
  end

  // After serving channel i the next search begins just past it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if ((RR != 0) && advance) begin
      ptr <= (grant_idx == IDXW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/arb_mux_reg.sv
// arb_mux_reg: N-input, W-bit arbitrating mux with valid/ready handshakes and
// one registered output stage that holds steady under backpressure.
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   in_data   in   N*W, channel i at [i*W +: W]
//   in_valid  in   N, channel i offers data
//   in_ready  out  N, channel i accepted when in_valid[i] & in_ready[i]
//   out_data  out  W, registered selected word
//   out_src   out  IDXW, channel that supplied out_data
//   out_valid out  out_data/out_src valid
//   out_ready in   consumer accepts when out_valid & out_ready
module arb_mux_reg
  import confused_pkg::*;
#(
  parameter int W  = WORD_W,
  parameter int N  = 4,
  parameter int RR = 1,
  localparam int IDXW = idx_w(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic [IDXW-1:0] out_src,
  output logic            out_valid,
  input  logic            out_ready
);

  logic            load;
  logic            advance;
  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic [IDXW-1:0] grant_idx;
  logic [W-1:0]    sel_data;

  // Masking requests during reset keeps in_ready low without waiting for a clock.
  assign req      = reset ? '0 : in_valid;
  assign load     = ~out_valid | out_ready;
  assign in_ready = grant & {N{load}};
  assign advance  = |(in_valid & in_ready);

  rr_arbiter #(
    .N (N),
    .RR(RR)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .advance  (advance),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  // Grant is one-hot, so a flat AND-OR is enough; no priority chain.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      sel_data = sel_data | (in_data[i*W +: W] & {W{grant[i]}});
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (load) begin
      if (|grant) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_src   <= grant_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux_reg.sv
module tb_arb_mux_reg;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // a: N=4 round-robin
  logic [63:0] a_data;
  logic [3:0]  a_valid, a_ready;
  logic [15:0] a_odata;
  logic [1:0]  a_osrc;
  logic        a_ovalid, a_oready;
  // b: N=4 fixed priority
  logic [63:0] b_data;
  logic [3:0]  b_valid, b_ready;
  logic [15:0] b_odata;
  logic [1:0]  b_osrc;
  logic        b_ovalid, b_oready;
  // c: N=5 round-robin
  logic [79:0] c_data;
  logic [4:0]  c_valid, c_ready;
  logic [15:0] c_odata;
  logic [2:0]  c_osrc;
  logic        c_ovalid, c_oready;
  // d: N=1
  logic [15:0] d_data;
  logic [0:0]  d_valid, d_ready;
  logic [15:0] d_odata;
  logic [0:0]  d_osrc;
  logic        d_ovalid, d_oready;

  arb_mux_reg #(.W(16), .N(4), .RR(1)) u_a (
    .clk(clk), .reset(reset), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .out_data(a_odata), .out_src(a_osrc), .out_valid(a_ovalid), .out_ready(a_oready));
  arb_mux_reg #(.W(16), .N(4), .RR(0)) u_b (
    .clk(clk), .reset(reset), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .out_data(b_odata), .out_src(b_osrc), .out_valid(b_ovalid), .out_ready(b_oready));
  arb_mux_reg #(.W(16), .N(5), .RR(1)) u_c (
    .clk(clk), .reset(reset), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
    .out_data(c_odata), .out_src(c_osrc), .out_valid(c_ovalid), .out_ready(c_oready));
  arb_mux_reg #(.W(16), .N(1), .RR(1)) u_d (
    .clk(clk), .reset(reset), .in_data(d_data), .in_valid(d_valid), .in_ready(d_ready),
    .out_data(d_odata), .out_src(d_osrc), .out_valid(d_ovalid), .out_ready(d_oready));

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  v;
    logic        ordy;
    logic [3:0]  er;
    logic        eov;
    logic [1:0]  es;
    logic [15:0] ed;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step_a(input string tag, input logic [3:0] v, input logic ordy,
                        input logic [3:0] er, input logic eov, input logic [1:0] es,
                        input logic [15:0] ed);
    a_valid  = v;
    a_oready = ordy;
    #2;
    check({tag, "_in_ready"},  a_ready,  er);
    check({tag, "_out_valid"}, a_ovalid, eov);
    check({tag, "_out_src"},   a_osrc,   es);
    check({tag, "_out_data"},  a_odata,  ed);
    @(negedge clk);
  endtask

  function automatic logic [15:0] model_grant(input int n, input int ptr, input logic [15:0] v);
    logic [15:0] g;
    g = '0;
    for (int k = 0; k < n; k++) begin
      if (v[(ptr + k) % n]) begin
        g[(ptr + k) % n] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  // Reference model of one cycle for a round-robin build.
  task automatic model_step(input int n, input logic [15:0] v, input logic ordy,
                            inout int ptr, inout logic ov,
                            output logic [15:0] rdy, output int idx);
    logic ld;
    ld  = !ov || ordy;
    rdy = ld ? model_grant(n, ptr, v) : 16'h0;
    idx = -1;
    for (int i = 0; i < n; i++) if (rdy[i]) idx = i;
    if (idx >= 0) begin
      ov  = 1'b1;
      ptr = (idx + 1) % n;
    end else if (ld) begin
      ov = 1'b0;
    end
  endtask

  logic [19:0] c_q[$];
  logic [19:0] d_q[$];
  int          c_ptr, d_ptr, idx;
  logic        c_ov, d_ov;
  logic [15:0] rdy;
  logic [19:0] e;
  logic [4:0]  c_done;
  logic [0:0]  d_done;
  logic [15:0] wctr;
  bit          gen;

  initial begin
    tbl[0] = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 16'h0000};
    tbl[1] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 16'h00A0};
    tbl[2] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 16'h00A1};
    tbl[3] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 16'h00A2};
    tbl[4] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 16'h00A3};
    tbl[5] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 16'h00A0};

    reset    = 1'b1;
    a_data   = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
    a_valid  = 4'b1111;
    a_oready = 1'b1;
    b_data   = '0; b_valid = '0; b_oready = 1'b1;
    c_data   = '0; c_valid = '0; c_oready = 1'b1;
    d_data   = '0; d_valid = '0; d_oready = 1'b1;
    #3;
    check("rst_in_ready",  a_ready,  4'b0000);
    check("rst_out_valid", a_ovalid, 1'b0);
    check("rst_out_data",  a_odata,  16'h0);
    check("rst_out_src",   a_osrc,   2'd0);
    @(negedge clk);
    reset = 1'b0;

    // Round-robin rotation with every channel requesting.
    for (int i = 0; i < 6; i++)
      step_a($sformatf("rr%0d", i), tbl[i].v, tbl[i].ordy, tbl[i].er, tbl[i].eov,
             tbl[i].es, tbl[i].ed);

    // Backpressure: ch2 loads 1234, then the consumer stalls for 5 cycles.
    a_data[47:32] = 16'h1234;
    step_a("bp_load", 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd1, 16'h00A1);
    for (int k = 0; k < 5; k++) begin
      a_data[15:0]  = 16'h1000 + 16'(k);
      a_data[31:16] = 16'h2000 + 16'(k);
      step_a($sformatf("bp_hold%0d", k), 4'b0011, 1'b0, 4'b0000, 1'b1, 2'd2, 16'h1234);
    end
    // Release with only ch0 valid: ptr is 3, search wraps to ch0.
    a_data[15:0] = 16'h5555;
    step_a("bp_drain", 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd2, 16'h1234);
    step_a("idle",     4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 16'h5555);
    a_data = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
    step_a("ptr_kept", 4'b1111, 1'b1, 4'b0010, 1'b0, 2'd0, 16'h5555);

    // Reset while a word is held and another is being offered.
    a_valid = 4'b1111;
    #2;
    check("mid_pre_valid", a_ovalid, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_out_valid", a_ovalid, 1'b0);
    check("mid_out_data",  a_odata,  16'h0);
    check("mid_out_src",   a_osrc,   2'd0);
    check("mid_in_ready",  a_ready,  4'b0000);
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("post_rst_grant", a_ready,  4'b0001);
    check("post_rst_valid", a_ovalid, 1'b0);
    @(negedge clk);
    a_valid = '0;

    // Fixed priority: ch1 always beats ch3.
    b_data  = {16'hDEAD, 16'h0000, 16'hBEEF, 16'h0000};
    b_valid = 4'b1010;
    #2;
    check("fp_ready0", b_ready, 4'b0010);
    @(negedge clk);
    for (int k = 1; k < 5; k++) begin
      #2;
      check($sformatf("fp_ready%0d", k), b_ready, 4'b0010);
      check($sformatf("fp_src%0d", k),   b_osrc,  2'd1);
      check($sformatf("fp_data%0d", k),  b_odata, 16'hBEEF);
      @(negedge clk);
    end
    b_valid = 4'b1000;
    #2;
    check("fp_ch3_after", b_ready, 4'b1000);
    @(negedge clk);
    b_valid = '0;

    // N=5 wrap: ch3 then ch4, pointer returns to 0.
    c_data[63:48] = 16'h3333;
    c_data[79:64] = 16'h4444;
    c_valid = 5'b01000;
    #2; check("n5_ch3", c_ready, 5'b01000); @(negedge clk);
    c_valid = 5'b10000;
    #2; check("n5_ch4", c_ready, 5'b10000); @(negedge clk);
    c_valid = 5'b11111;
    #2;
    check("n5_wrap_grant", c_ready, 5'b00001);
    check("n5_wrap_src",   c_osrc,  3'd4);
    check("n5_wrap_data",  c_odata, 16'h4444);
    @(negedge clk);
    c_valid = '0;
    c_data  = '0;
    @(negedge clk);

    // Randomised traffic with scoreboard on N=5 and N=1.
    c_ptr = 1; c_ov = 1'b0;
    d_ptr = 0; d_ov = 1'b0;
    c_done = '0; d_done = '0;
    wctr = 16'h0100;
    for (int cyc = 0; cyc < 10020; cyc++) begin
      gen = (cyc < 10000);
      for (int i = 0; i < 5; i++) begin
        if (c_done[i]) c_valid[i] = 1'b0;
        if (gen && !c_valid[i] && $urandom_range(0, 2) != 0) begin
          c_valid[i] = 1'b1;
          c_data[i*16 +: 16] = wctr;
          wctr++;
        end
      end
      if (d_done[0]) d_valid[0] = 1'b0;
      if (gen && !d_valid[0] && $urandom_range(0, 3) != 0) begin
        d_valid[0] = 1'b1;
        d_data = wctr;
        wctr++;
      end
      c_oready = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
      d_oready = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
      #2;

      check("n5_out_valid", c_ovalid, c_ov);
      if (c_ovalid && c_oready) begin
        if (c_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL n5_sb: got word %0h expected none", c_odata);
        end else begin
          e = c_q.pop_front();
          check("n5_out_data", c_odata, e[15:0]);
          check("n5_out_src",  c_osrc,  e[19:16]);
        end
      end
      model_step(5, {11'b0, c_valid}, c_oready, c_ptr, c_ov, rdy, idx);
      check("n5_in_ready", c_ready, rdy[4:0]);
      if (idx >= 0) c_q.push_back({4'(idx), c_data[idx*16 +: 16]});
      c_done = c_valid & c_ready;

      check("n1_out_valid", d_ovalid, d_ov);
      if (d_ovalid && d_oready) begin
        if (d_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL n1_sb: got word %0h expected none", d_odata);
        end else begin
          e = d_q.pop_front();
          check("n1_out_data", d_odata, e[15:0]);
          check("n1_out_src",  d_osrc,  e[19:16]);
        end
      end
      model_step(1, {15'b0, d_valid}, d_oready, d_ptr, d_ov, rdy, idx);
      check("n1_in_ready", d_ready, rdy[0:0]);
      if (idx >= 0) d_q.push_back({4'd0, d_data});
      d_done = d_valid & d_ready;

      @(negedge clk);
    end
    check("n5_sb_left", c_q.size(), 0);
    check("n1_sb_left", d_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
